box_draw_arbiter: RTL and testbench

- Shares the single VGA adapter pixel-write port between several box-drawing requesters (player 1 mover, player 2 mover, box reset sequencer).
- Grants one requester at a time, round-robin, and latches its box origin and colour.
- Scans the box as a BOX_W x BOX_H pixel block, one pixel per cycle, driving x/y/colour/plot to the adapter.
- Acknowledges the requester when the box is complete.

---
 rtl/box_draw_arbiter.sv | 158 +++++++++++++++
 tb/tb_box_draw_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_draw_arbiter.sv
// box_draw_arbiter: shares one VGA adapter pixel-write port between several
// box-drawing requesters. A round-robin winner is granted, its origin and
// colour are latched, and the box is scanned row-major, one pixel per cycle.
//
// Handshake: a requester raises req (level) and holds it until it sees a
// one-cycle ack pulse. grant is high while it owns the port. Dropping req
// before grant withdraws the request; dropping it after grant changes nothing.
//
// Optional build macro: BOX_ARB_RESET_PRIORITY_EN -- requester 0 (reset
// sequencer) always wins in IDLE when requesting. Round-robin then runs only
// among requesters 1..NUM_REQ-1, and rr_ptr is left alone when 0 wins.
module box_draw_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int BOX_W   = 4,
  parameter int BOX_H   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [7*NUM_REQ-1:0] req_y,
  input  logic [3*NUM_REQ-1:0] req_colour,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] pick;
  logic          pick_valid;
  logic [IW-1:0] rr_next;
  logic [3:0]    dx, dy;
  logic [3:0]    ndx, ndy;
  logic          last_col, last_row;
  logic [7:0]    base_x;
  logic [6:0]    base_y;

  assign dbg_state = state;

  // Round-robin search from rr_ptr; first high request bit wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
`ifdef BOX_ARB_RESET_PRIORITY_EN
    if (req[0]) begin
      pick_valid = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!pick_valid && idx != 0 && req[idx]) begin
          pick       = IW'(idx);
          pick_valid = 1'b1;
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_valid && req[idx]) begin
        pick       = IW'(idx);
        pick_valid = 1'b1;
      end
    end
`endif
  end

  // Scan position of the pixel after the one being presented.
  always_comb begin
    last_col = (dx == 4'(BOX_W - 1));
    last_row = (dy == 4'(BOX_H - 1));
    ndx      = last_col ? 4'd0 : dx + 4'd1;
    ndy      = last_col ? dy + 4'd1 : dy;
    rr_next  = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // Arbitration / latch / scan / acknowledge state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      winner <= '0;
      grant  <= '0;
      ack    <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      dx     <= '0;
      dy     <= '0;
      base_x <= '0;
      base_y <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (pick_valid) begin
            winner <= pick;
            grant  <= ONE << pick;
            busy   <= 1'b1;
            state  <= LATCH;
          end
        end
        LATCH: begin
          // Origin and colour are frozen here; later input changes are ignored.
          base_x <= req_x[8*winner +: 8];
          base_y <= req_y[7*winner +: 7];
          colour <= req_colour[3*winner +: 3];
          x      <= req_x[8*winner +: 8];
          y      <= req_y[7*winner +: 7];
          dx     <= '0;
          dy     <= '0;
          plot   <= 1'b1;
          state  <= DRAW;
        end
        DRAW: begin
          if (last_col && last_row) begin
            plot  <= 1'b0;
            ack   <= ONE << winner;
            grant <= '0;
`ifdef BOX_ARB_RESET_PRIORITY_EN
            if (winner != '0) rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
            state <= DONE;
          end else begin
            dx <= ndx;
            dy <= ndy;
            x  <= base_x + {4'b0, ndx};
            y  <= base_y + {3'b0, ndy};
          end
        end
        DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_draw_arbiter.sv
// tb_box_draw_arbiter: random and directed stimulus for box_draw_arbiter.
// A reference model predicts every pixel (with its cycle) and every ack from
// the arbitration rules; a monitor pops and compares whenever plot or ack fires.
module tb_box_draw_arbiter;

  localparam int NR   = 3;
  localparam int BW   = 4;
  localparam int BH   = 4;
  localparam int NPIX = BW * BH;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req;
  logic [8*NR-1:0] req_x;
  logic [7*NR-1:0] req_y;
  logic [3*NR-1:0] req_colour;
  logic [NR-1:0] grant;
  logic [NR-1:0] ack;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [2:0]    colour;
  logic          plot;
  logic          busy;
  logic [1:0]    dbg_state;

  box_draw_arbiter #(.NUM_REQ(NR), .BOX_W(BW), .BOX_H(BH)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .ack(ack), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // {cycle[15:0], grant[2:0], x[7:0], y[6:0], colour[2:0]}
  logic [36:0] exp_q[$];
  // {cycle[15:0], ack[2:0]}
  logic [18:0] ack_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got nothing expected event (cycle %0d)", name, cyc);
  endtask

  // Reference model: a box occupies the port for grant, NPIX pixels, ack,
  // then one idle cycle before the next arbitration.
  int         m_rr   = 0;
  int         m_free = 0;
  int         m_win  = 0;
  bit         m_pend = 0;
  logic [7:0] m_bx;
  logic [6:0] m_by;
  logic [2:0] m_bc;
  int         m_px, m_py;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      exp_q.delete();
      ack_q.delete();
      m_rr   = 0;
      m_pend = 0;
      m_free = cyc + 1;
    end else if (m_pend) begin
      m_bx = req_x[8*m_win +: 8];
      m_by = req_y[7*m_win +: 7];
      m_bc = req_colour[3*m_win +: 3];
      for (int r = 0; r < BH; r++) begin
        for (int c = 0; c < BW; c++) begin
          m_px = (int'(m_bx) + c) % 256;
          m_py = (int'(m_by) + r) % 128;
          exp_q.push_back({16'(cyc + r*BW + c), 3'(1 << m_win), m_px[7:0], m_py[6:0], m_bc});
        end
      end
      ack_q.push_back({16'(cyc + NPIX), 3'(1 << m_win)});
      m_free = cyc + NPIX + 2;
`ifdef BOX_ARB_RESET_PRIORITY_EN
      if (m_win != 0) m_rr = (m_win + 1) % NR;
`else
      m_rr = (m_win + 1) % NR;
`endif
      m_pend = 0;
    end else if (cyc >= m_free && req != 0) begin
`ifdef BOX_ARB_RESET_PRIORITY_EN
      if (req[0]) begin
        m_win = 0;
      end else begin
        m_win = -1;
        for (int k = 0; k < NR; k++)
          if (m_win < 0 && ((m_rr + k) % NR) != 0 && req[(m_rr + k) % NR]) m_win = (m_rr + k) % NR;
      end
`else
      m_win = -1;
      for (int k = 0; k < NR; k++)
        if (m_win < 0 && req[(m_rr + k) % NR]) m_win = (m_rr + k) % NR;
`endif
      m_pend = 1;
    end
  end

  // Scoreboard monitor
  logic [36:0] m_e;
  logic [18:0] m_a;
  always @(negedge clk) begin
    if (plot) begin
      if (exp_q.size() == 0) fail_now("unexpected_plot");
      else begin
        m_e = exp_q.pop_front();
        check("pixel{cyc,grant,x,y,colour}", {27'b0, cyc[15:0], grant, x, y, colour}, {27'b0, m_e});
      end
    end
    if (ack != 0) begin
      if (ack_q.size() == 0) fail_now("unexpected_ack");
      else begin
        m_a = ack_q.pop_front();
        check("ack{cyc,ack}", {45'b0, cyc[15:0], ack}, {45'b0, m_a});
        check("done{grant,plot,busy}", {59'b0, grant, plot, busy}, {59'b0, 3'b000, 1'b0, 1'b1});
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack_any(output int idx);
    idx = -1;
    for (int t = 0; t < 300; t++) begin
      step();
      if (ack != 0) begin
        for (int i = 0; i < NR; i++) if (ack[i]) idx = i;
        return;
      end
    end
    fail_now("ack_timeout");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int idx;
  int cnt;
  int order[4];

  initial begin
    reset = 1'b1;
    req = '0; req_x = '0; req_y = '0; req_colour = '0;
    repeat (3) step();
    @(negedge clk);
    check("reset_grant", grant, 0);
    check("reset_ack", ack, 0);
    check("reset_x", x, 0);
    check("reset_y", y, 0);
    check("reset_colour", colour, 0);
    check("reset_plot", plot, 0);
    check("reset_busy", busy, 0);
    step();
    reset = 1'b0;
    step();

    // Single request from player 1
    req_x[15:8] = 8'd43; req_y[13:7] = 7'd7; req_colour[5:3] = 3'b100;
    req = 3'b010;
    wait_ack_any(idx);
    check("single_ack_idx", idx, 1);
    req = '0;
    repeat (3) step();

    // Contention from a fresh round-robin pointer
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_x[8*i +: 8] = 8'($urandom); req_y[7*i +: 7] = 7'($urandom);
      req_colour[3*i +: 3] = 3'($urandom);
    end
`ifdef BOX_ARB_RESET_PRIORITY_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 2, 0};
`endif
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack_any(idx);
      check("contention_order", idx, order[k]);
    end
    req = '0;
    repeat (3) step();

    // Coordinate wrap-around
    req_x[23:16] = 8'd254; req_y[20:14] = 7'd126; req_colour[8:6] = 3'b011;
    req = 3'b100;
    wait_ack_any(idx);
    check("wrap_ack_idx", idx, 2);
    req = '0;
    repeat (3) step();

    // Withdrawn request and late origin change
    req_x[15:8] = 8'd10; req_y[13:7] = 7'd20;
    req = 3'b010;
    repeat (4) step();
    req[0] = 1'b1;
    req_x[15:8] = 8'd200;
    repeat (3) step();
    req[0] = 1'b0;
    wait_ack_any(idx);
    check("withdraw_ack_idx", idx, 1);
    req = '0;
    repeat (25) step();

`ifdef BOX_ARB_RESET_PRIORITY_EN
    // Requester 0 beats a non-zero rr_ptr
    req = 3'b010;
    wait_ack_any(idx);
    req = 3'b011;
    wait_ack_any(idx);
    check("prio_first", idx, 0);
    req[0] = 1'b0;
    wait_ack_any(idx);
    check("prio_second", idx, 1);
    req = '0;
    repeat (3) step();
`endif

    // Reset on the fifth plot cycle
    req = 3'b100;
    cnt = 0;
    for (int t = 0; t < 100 && cnt < 5; t++) begin
      step();
      if (plot) cnt++;
    end
    if (cnt < 5) fail_now("plot_timeout");
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 3'b110;
    @(negedge clk);
    check("midreset_plot", plot, 0);
    check("midreset_grant", grant, 0);
    check("midreset_ack", ack, 0);
    check("midreset_busy", busy, 0);
    wait_ack_any(idx);
    check("midreset_first", idx, 1);
    req[1] = 1'b0;
    wait_ack_any(idx);
    check("midreset_second", idx, 2);
    req = '0;
    repeat (3) step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (ack[i] && $urandom_range(3) != 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(7) == 0) req[i] = 1'b1;
        else if (req[i] && !grant[i] && $urandom_range(15) == 0) req[i] = 1'b0;
        if ($urandom_range(3) == 0) begin
          req_x[8*i +: 8] = 8'($urandom);
          req_y[7*i +: 7] = 7'($urandom);
          req_colour[3*i +: 3] = 3'($urandom);
        end
      end
    end
    req = '0;
    for (int t = 0; t < 200 && (exp_q.size() != 0 || ack_q.size() != 0); t++) step();
    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
